// File: rtl/vpu_vram_arbiter_if.sv
// Signal bundle around one shared VRAM: VPU read port, CPU req/ready/rvalid port and RAM port.
// slave = arbiter view; master = requesters plus the RAM instance.
interface vpu_vram_arbiter_if #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int STALL_W = 16
);
    logic                  vpu_busy;
    logic                  vpu_en;
    logic [ADDR_W-1:0]     vpu_addr;
    logic [DATA_W-1:0]     vpu_dout;

    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_W-1:0]     cpu_addr;
    logic [DATA_W-1:0]     cpu_wdata;
    logic [DATA_W/8-1:0]   cpu_wstrb;
    logic                  cpu_ready;
    logic                  cpu_rvalid;
    logic [DATA_W-1:0]     cpu_rdata;
    logic [STALL_W-1:0]    cpu_stall_cnt;

    logic                  ram_en;
    logic [DATA_W/8-1:0]   ram_we;
    logic [ADDR_W-1:0]     ram_addr;
    logic [DATA_W-1:0]     ram_din;
    logic [DATA_W-1:0]     ram_dout;

    modport slave (
        input  vpu_busy, vpu_en, vpu_addr,
        output vpu_dout,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
        output cpu_ready, cpu_rvalid, cpu_rdata, cpu_stall_cnt,
        output ram_en, ram_we, ram_addr, ram_din,
        input  ram_dout
    );

    modport master (
        output vpu_busy, vpu_en, vpu_addr,
        input  vpu_dout,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
        input  cpu_ready, cpu_rvalid, cpu_rdata, cpu_stall_cnt,
        input  ram_en, ram_we, ram_addr, ram_din,
        output ram_dout
    );
endinterface

// File: rtl/vpu_vram_arbiter.sv
// Single-port VRAM arbiter: VPU has absolute priority while busy, CPU is served in idle cycles.
// Optional one-entry posted write buffer enabled by defining VPU_VRAM_WPOST_EN.
module vpu_vram_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int STALL_W = 16
) (
    input logic               clk,
    input logic               rst_n,
    vpu_vram_arbiter_if.slave bus
);
    localparam int STRB_W = DATA_W / 8;

    logic               rd_grant;
    logic               wr_grant;
    logic               wr_accept;
    logic               wb_empty;
    logic               cpu_ready;

    logic               ram_en;
    logic [STRB_W-1:0]  ram_we;
    logic [ADDR_W-1:0]  ram_addr;
    logic [DATA_W-1:0]  ram_din;

    logic               rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [STALL_W-1:0] stall_q, stall_d;

`ifdef VPU_VRAM_WPOST_EN
    logic               drain;
    logic               wr_post;
    logic               wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0]  wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]  wb_data_q, wb_data_d;
    logic [STRB_W-1:0]  wb_strb_q, wb_strb_d;

    assign wb_empty  = ~wb_valid_q;
    assign drain     = rst_n & ~bus.vpu_busy & wb_valid_q;
    assign wr_post   = rst_n & bus.vpu_busy & bus.cpu_req & bus.cpu_we & wb_empty;
    assign wr_accept = wr_grant | wr_post;

    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        wb_strb_d  = wb_strb_q;
        if (drain) begin
            wb_valid_d = 1'b0;
        end
        if (wr_post) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = bus.cpu_addr;
            wb_data_d  = bus.cpu_wdata;
            wb_strb_d  = bus.cpu_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            wb_strb_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            wb_strb_q  <= wb_strb_d;
        end
    end
`else
    assign wb_empty  = 1'b1;
    assign wr_accept = wr_grant;
`endif

    // Direct CPU grants only in idle cycles; a full buffer blocks both (it drains first).
    assign wr_grant  = rst_n & ~bus.vpu_busy & bus.cpu_req &  bus.cpu_we & wb_empty;
    assign rd_grant  = rst_n & ~bus.vpu_busy & bus.cpu_req & ~bus.cpu_we & wb_empty;
    assign cpu_ready = rd_grant | wr_accept;

    always_comb begin
        ram_en   = 1'b0;
        ram_we   = '0;
        ram_addr = bus.vpu_addr;
        ram_din  = bus.cpu_wdata;
        if (bus.vpu_busy) begin
            ram_en = bus.vpu_en;
`ifdef VPU_VRAM_WPOST_EN
        end else if (drain) begin
            ram_en   = 1'b1;
            ram_we   = wb_strb_q;
            ram_addr = wb_addr_q;
            ram_din  = wb_data_q;
`endif
        end else if (wr_grant) begin
            ram_en   = 1'b1;
            ram_we   = bus.cpu_wstrb;
            ram_addr = bus.cpu_addr;
        end else if (rd_grant) begin
            ram_en   = 1'b1;
            ram_addr = bus.cpu_addr;
        end
    end

    always_comb begin
        rd_pend_d = rd_grant;
        rdata_d   = rd_pend_q ? bus.ram_dout : rdata_q;
        stall_d   = stall_q;
        if (cpu_ready) begin
            stall_d = '0;
        end else if (bus.cpu_req && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend_q <= 1'b0;
            rdata_q   <= '0;
            stall_q   <= '0;
        end else begin
            rd_pend_q <= rd_pend_d;
            rdata_q   <= rdata_d;
            stall_q   <= stall_d;
        end
    end

    assign bus.ram_en   = ram_en;
    assign bus.ram_we   = ram_we;
    assign bus.ram_addr = ram_addr;
    assign bus.ram_din  = ram_din;
    assign bus.vpu_dout = bus.ram_dout;

    // Outputs are forced to reset values while rst_n is low, so a read pending
    // in the reset cycle never shows its rvalid.
    assign bus.cpu_ready     = cpu_ready;
    assign bus.cpu_rvalid    = rd_pend_q & rst_n;
    assign bus.cpu_rdata     = !rst_n ? '0 : (rd_pend_q ? bus.ram_dout : rdata_q);
    assign bus.cpu_stall_cnt = rst_n ? stall_q : '0;
endmodule

// File: tb/tb_vpu_vram_arbiter.sv
// Randomised + directed bench for vpu_vram_arbiter against a transaction-level model
// (shadow memory, read-response queue, posted-write queue, wait counter).
module tb_vpu_vram_arbiter;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int STALL_W = 16;
`ifdef VPU_VRAM_WPOST_EN
    localparam bit WPOST = 1'b1;
`else
    localparam bit WPOST = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    vpu_vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STALL_W(STALL_W)) bus ();

    vpu_vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STALL_W(STALL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // RAM instance with registered read port and byte enables
    bit [31:0] mem [65536];
    bit [31:0] ram_q;
    assign bus.ram_dout = ram_q;

    always @(posedge clk) begin
        if (bus.ram_en) begin
            ram_q <= mem[bus.ram_addr];
            for (int b = 0; b < 4; b++)
                if (bus.ram_we[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_din[8*b +: 8];
        end
    end

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model state
    bit [31:0]   shadow [65536];
    bit [31:0]   m_dout;
    bit [31:0]   rdq [$];
    wr_t         wq [$];
    bit [31:0]   m_last;
    int unsigned m_stall;
    bit          model_on;
    int          busy_writes;

    always @(negedge clk) begin : model
        bit        go_rd, go_wr, go_post, go_drain, e_ready, e_en, e_rvalid;
        bit [3:0]  e_we;
        bit [15:0] e_addr;
        bit [31:0] e_din, e_rdata, rd;
        go_rd = 0; go_wr = 0; go_post = 0; go_drain = 0;
        if (rst_n) begin
            if (!bus.vpu_busy && wq.size() != 0) go_drain = 1;
            else if (!bus.vpu_busy && bus.cpu_req) begin
                if (bus.cpu_we) go_wr = 1; else go_rd = 1;
            end else if (WPOST && bus.vpu_busy && bus.cpu_req && bus.cpu_we && wq.size() == 0)
                go_post = 1;
        end
        e_ready = go_rd | go_wr | go_post;
        e_en = 0; e_we = 0; e_addr = bus.vpu_addr; e_din = 0; rd = 0;
        if (bus.vpu_busy) e_en = bus.vpu_en;
        else if (go_drain) begin e_en = 1; e_we = wq[0].s; e_addr = wq[0].a; e_din = wq[0].d; end
        else if (go_wr) begin e_en = 1; e_we = bus.cpu_wstrb; e_addr = bus.cpu_addr; e_din = bus.cpu_wdata; end
        else if (go_rd) begin e_en = 1; e_addr = bus.cpu_addr; end
        e_rvalid = rst_n && rdq.size() != 0;
        e_rdata  = !rst_n ? 32'h0 : (rdq.size() != 0 ? rdq[0] : m_last);
        if (bus.vpu_busy && bus.ram_we != 4'h0) busy_writes++;

        if (model_on) begin
            check("ram_en", bus.ram_en, e_en);
            check("ram_we", bus.ram_we, e_we);
            if (e_en) check("ram_addr", bus.ram_addr, e_addr);
            if (e_we != 0) check("ram_din", bus.ram_din, e_din);
            check("cpu_ready", bus.cpu_ready, e_ready);
            check("cpu_rvalid", bus.cpu_rvalid, e_rvalid);
            check("cpu_rdata", bus.cpu_rdata, e_rdata);
            check("cpu_stall_cnt", bus.cpu_stall_cnt, rst_n ? m_stall : 0);
            check("vpu_dout", bus.vpu_dout, m_dout);
        end

        if (e_en) begin
            rd = shadow[e_addr];
            for (int b = 0; b < 4; b++)
                if (e_we[b]) shadow[e_addr][8*b +: 8] = e_din[8*b +: 8];
            m_dout = rd;
        end
        if (rdq.size() != 0) m_last = rdq.pop_front();
        if (go_rd) rdq.push_back(rd);
        if (go_post) wq.push_back('{a: bus.cpu_addr, d: bus.cpu_wdata, s: bus.cpu_wstrb});
        if (go_drain) wq.delete(0);
        if (!rst_n) begin
            rdq.delete(); wq.delete(); m_last = 0; m_stall = 0; model_on = 1;
        end else if (e_ready) m_stall = 0;
        else if (bus.cpu_req && m_stall < 65535) m_stall++;
    end

    task automatic wait_ready(output int stall_at);
        bit ok = 0;
        stall_at = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.cpu_ready) begin
                ok = 1;
                stall_at = int'(bus.cpu_stall_cnt);
                break;
            end
        end
        @(posedge clk); #1;
        check("ready_timeout", ok, 1'b1);
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s, output int st);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
        bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_wstrb = s;
        wait_ready(st);
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [31:0] d, output int st);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = a;
        wait_ready(st);
        bus.cpu_req = 1'b0;
        @(negedge clk);
        check("rd_rvalid", bus.cpu_rvalid, 1'b1);
        d = bus.cpu_rdata;
        @(posedge clk); #1;
    endtask

    initial begin : main
        int          st;
        logic [31:0] d;
        bit          pend;
        bus.vpu_busy = 1'b0; bus.vpu_en = 1'b0; bus.vpu_addr = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0;
        bus.cpu_wdata = '0; bus.cpu_wstrb = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", bus.cpu_ready, 1'b0);
        check("rst_rvalid", bus.cpu_rvalid, 1'b0);
        check("rst_rdata", bus.cpu_rdata, 32'h0);
        check("rst_stall", bus.cpu_stall_cnt, 16'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // preload
        cpu_write(16'h1234, 32'hDEADBEEF, 4'hF, st);
        for (int i = 0; i < 5; i++) cpu_write(16'(16'h0280 + i), 32'hC0DE0280 + i, 4'hF, st);

        // CPU read in blank
        cpu_read(16'h1234, d, st);
        check("blank_rd_data", d, 32'hDEADBEEF);
        check("blank_rd_stall", st, 0);

        // VPU-only window
        bus.vpu_busy = 1'b1; bus.vpu_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) bus.vpu_addr = 16'(16'h0280 + i); else bus.vpu_en = 1'b0;
            @(negedge clk);
            if (i < 5) check("vpu_ram_addr", bus.ram_addr, 16'h0280 + i);
            if (i > 0) check("vpu_dout_lit", bus.vpu_dout, 32'hC0DE0280 + i - 1);
            check("vpu_ram_we", bus.ram_we, 4'h0);
            @(posedge clk); #1;
        end
        bus.vpu_busy = 1'b0;

        // contention: write raised at the start of an 80-cycle busy window
        bus.vpu_busy = 1'b1;
        fork
            begin repeat (80) @(posedge clk); #1; bus.vpu_busy = 1'b0; end
        join_none
        cpu_write(16'h0010, 32'hA5A5A5A5, 4'hF, st);
        check("contention_stall", st, WPOST ? 0 : 80);
        for (int i = 0; i < 200 && bus.vpu_busy; i++) begin @(posedge clk); #1; end
        @(negedge clk);
        check("stall_cleared", bus.cpu_stall_cnt, 16'h0);
        @(posedge clk); #1;
        cpu_read(16'h0010, d, st);
        check("contention_data", d, 32'hA5A5A5A5);

        // byte strobes, including an all-zero strobe write
        cpu_write(16'h0020, 32'h11223344, 4'hF, st);
        cpu_write(16'h0020, 32'hFFFFFFFF, 4'b0101, st);
        cpu_write(16'h0020, 32'h00000000, 4'b0000, st);
        cpu_read(16'h0020, d, st);
        check("strobe_data", d, 32'h11FF33FF);

        // write then read of the same word during a 6-cycle busy window
        bus.vpu_busy = 1'b1; bus.vpu_en = 1'b1; bus.vpu_addr = 16'h0005;
        fork
            begin repeat (6) @(posedge clk); #1; bus.vpu_busy = 1'b0; end
        join_none
        cpu_write(16'h0030, 32'h00000001, 4'hF, st);
        check("raw_wr_stall", st, WPOST ? 0 : 6);
        cpu_read(16'h0030, d, st);
        check("raw_rd_stall", st, WPOST ? 6 : 0);
        check("raw_rd_data", d, 32'h00000001);
        bus.vpu_en = 1'b0;

        // reset during T+1 of a read
        cpu_write(16'h0040, 32'h5A5A0001, 4'hF, st);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0040;
        wait_ready(st);
        rst_n = 1'b0; bus.cpu_req = 1'b0;
        @(negedge clk);
        check("rstrd_rvalid", bus.cpu_rvalid, 1'b0);
        check("rstrd_rdata", bus.cpu_rdata, 32'h0);
        check("rstrd_stall", bus.cpu_stall_cnt, 16'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rstrd_rvalid_after", bus.cpu_rvalid, 1'b0);
        check("rstrd_rdata_after", bus.cpu_rdata, 32'h0);
        @(posedge clk); #1;

        // randomised traffic
        pend = 0;
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 7) == 0) bus.vpu_busy = ~bus.vpu_busy;
            bus.vpu_en   = 1'($urandom_range(0, 1));
            bus.vpu_addr = 16'($urandom_range(0, 31));
            if (!pend) begin
                if ($urandom_range(0, 2) != 0) begin
                    pend = 1;
                    bus.cpu_req   = 1'b1;
                    bus.cpu_we    = 1'($urandom_range(0, 1));
                    bus.cpu_addr  = 16'($urandom_range(0, 31));
                    bus.cpu_wdata = $urandom();
                    bus.cpu_wstrb = 4'($urandom_range(0, 15));
                end else begin
                    bus.cpu_req = 1'b0;
                end
            end
            @(negedge clk);
            if (bus.cpu_ready) pend = 0;
            @(posedge clk); #1;
        end
        rst_n = 1'b1; bus.cpu_req = 1'b0; bus.vpu_busy = 1'b0;
        repeat (4) begin @(posedge clk); #1; end

        check("no_write_while_busy", busy_writes, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
